fp_scale_pow2_pipe: RTL and testbench
=====================================

Name: fp_scale_pow2_pipe

Overview:
Pipelined, multi-lane floating-point multiply-by-2^k unit with a runtime signed power, per-lane negate and IEEE-style special-value handling. It replaces the fixed-power combinational scaler in the inference datapath, for example for activation scaling and quantisation rescale between layers. It sits between accumulator output and activation stages on a valid/ready stream and reports per-lane and sticky overflow/underflow status.

Parameters:
FLOATSIZE, 16, total float width
EXPONENTSIZE, 5, exponent field width; significand = FLOATSIZE-EXPONENTSIZE-1
LANES, 4, parallel lanes per beat
POWER_WIDTH, 6, width of signed runtime power
SATURATE, 1, overflow result: 1 = max finite, 0 = signed infinity

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept beat
in_data  in  LANES*FLOATSIZE  lane i at bits [i*FLOATSIZE +: FLOATSIZE]
in_power  in  POWER_WIDTH  signed power k, shared by all lanes of the beat
in_negate  in  LANES  per-lane sign flip
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*FLOATSIZE  scaled results
out_ovf  out  LANES  per-lane overflow flag, aligned with out_data
out_unf  out  LANES  per-lane underflow flag, aligned with out_data
clear_sticky  in  1  clears sticky flags
sticky_ovf  out  1  any overflow since last clear
sticky_unf  out  1  any underflow since last clear

Behaviour:
- One clock, clk. Synchronous active-low reset rst_n. All state updates on the rising edge.
- Two-stage pipeline, S1 then S2. Each stage holds a valid bit. Latency is 2 cycles from input handshake to out_valid when there is no stall.
- A stage advances when it is empty or the stage after it advances. S2 advances on out_ready.
- in_ready = !s1_valid || (!s2_valid || out_ready). It is combinational and must not depend on in_valid.
- The handshake completes on valid&&ready. in_data, in_power and in_negate are captured only on handshake.
- Full throughput: 1 beat/cycle while out_ready=1. No beat is dropped or duplicated under any stall pattern.
- out_data and out flags stay stable while out_valid && !out_ready.
- S1 (registered): per lane, unpack sign, exponent and significand. Compute e' = exp + k in signed EXPONENTSIZE+2 bits. Classify the lane as zero (exp==0), special (exp all ones), overflow (e' >= 2^E-1) or underflow (e' <= 0).
- S2 (registered): form the result.
  - zero: output sign-flipped zero (if negate), no flags. Denormals are treated as zero.
  - special: pass inf/NaN through, with sign flipped if negate. NaN payload is kept. No flags.
  - overflow: out_ovf=1. Magnitude is {E'b1..10, S'b1..1} if SATURATE else {E'b1..1, 0}. Sign is kept.
  - underflow: out_unf=1. Output is signed zero (flush). Significand is discarded.
  - normal: {sign^negate, e'[E-1:0], significand}.
- k=0 is an exact pass-through apart from negate and flush of denormals.
- Sticky flags: set when an S2 beat with any ovf/unf completes the output handshake.
  - clear_sticky has priority over a set in the same cycle. The same-cycle event is lost. This is intended.
- Reset values: s1_valid=s2_valid=0, out_valid=0, out_data=0, out_ovf=out_unf=0, sticky_ovf=sticky_unf=0. in_ready=1 the cycle after reset is released.
- Reset mid-operation discards all in-flight beats. No partial beat is emitted afterwards.

Decomposition:
- Package fp_pkg holds:
  - typedef fp_class_e {FP_ZERO, FP_SPECIAL, FP_NORMAL, FP_OVF, FP_UNF}
  - functions exp_max(E) and sig_width(F,E)
  - constant helpers for max-finite and infinity patterns
- One sub-module, fp_scale_pow2_lane: per-lane classify and pack logic, combinational. Instantiated LANES times across the S1/S2 registers, which stay in the top level.

Test Plan:
- fp16, LANES=4, k=+4, data {0x3C00,0xBC00,0x4000,0x0000}, no negate -> after 2 cycles {0x4C00,0xCC00,0x5000,0x0000}, no flags.
- k=+2, lane0=0x7800, SATURATE=1 -> 0x7BFF, out_ovf[0]=1, sticky_ovf=1. With SATURATE=0 -> 0x7C00.
- k=-1, lanes {0x0400,0x8400} -> {0x0000,0x8000}, out_unf=2'b11, sticky_unf=1. Then clear_sticky=1 -> sticky_unf=0 next cycle.
- Specials: {0x7E00,0xFC00}, k=+5, in_negate=2'b11 -> {0xFE00,0x7C00}, no flags.
- Backpressure: stream 6 beats with out_ready low for cycles 3-5 -> in_ready=0 once both stages are full. All 6 beats are output in order, with no loss or duplication.
- Reset: assert rst_n=0 with 2 beats in flight -> out_valid=0, sticky flags 0, no stale beat after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constant helpers for the power-of-two float scaler.
// Provides the per-lane classification enum and width/pattern helpers.
package fp_pkg;

    // Per-lane class decided in S1 and used by S2 to build the result.
    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SPECIAL,
        FP_NORMAL,
        FP_OVF,
        FP_UNF
    } fp_class_e;

    // All-ones exponent code (inf/NaN) for an e-bit exponent field.
    function automatic int exp_max(input int e);
        return (1 << e) - 1;
    endfunction

    // Stored significand width, without the hidden bit.
    function automatic int sig_width(input int f, input int e);
        return f - e - 1;
    endfunction

    // Exponent code of the largest finite value.
    function automatic int max_finite_exp(input int e);
        return exp_max(e) - 1;
    endfunction

    // Exponent code of infinity.
    function automatic int inf_exp(input int e);
        return exp_max(e);
    endfunction

endpackage

// File: rtl/fp_scale_pow2_lane.sv
// Per-lane combinational logic for the power-of-two scaler.
// Classify half (feeds S1): unpacks in_float, adds the power to the
// exponent and classifies the lane. Pack half (fed by S1, feeds S2):
// builds the result float and the overflow/underflow flags.
// Ports:
//   in_float, power, negate        raw lane input, signed power, sign flip
//   cls_sign/kind/exp/sig          classification results for S1
//   res_sign/kind/exp/sig          registered S1 fields
//   res_float, res_ovf, res_unf    packed result and flags for S2
module fp_scale_pow2_lane
    import fp_pkg::*;
#(
    parameter int FLOATSIZE    = 16,
    parameter int EXPONENTSIZE = 5,
    parameter int POWER_WIDTH  = 6,
    parameter int SATURATE     = 1
) (
    input  logic [FLOATSIZE-1:0]              in_float,
    input  logic [POWER_WIDTH-1:0]            power,
    input  logic                              negate,
    output logic                              cls_sign,
    output fp_class_e                         cls_kind,
    output logic [EXPONENTSIZE-1:0]           cls_exp,
    output logic [FLOATSIZE-EXPONENTSIZE-2:0] cls_sig,
    input  logic                              res_sign,
    input  fp_class_e                         res_kind,
    input  logic [EXPONENTSIZE-1:0]           res_exp,
    input  logic [FLOATSIZE-EXPONENTSIZE-2:0] res_sig,
    output logic [FLOATSIZE-1:0]              res_float,
    output logic                              res_ovf,
    output logic                              res_unf
);

    localparam int E  = EXPONENTSIZE;
    localparam int S  = sig_width(FLOATSIZE, EXPONENTSIZE);
    localparam int EW = EXPONENTSIZE + 2;  // room for sign and carry of exp + k

    localparam logic signed [EW-1:0] OVF_LIMIT = EW'(exp_max(E));
    localparam logic [E-1:0]         MAX_EXP   = E'(max_finite_exp(E));
    localparam logic [E-1:0]         INF_EXP   = E'(inf_exp(E));

    logic [E-1:0]         exp_f;
    logic signed [EW-1:0] e_sum;

    assign exp_f = in_float[FLOATSIZE-2 -: E];
    assign e_sum = $signed({2'b00, exp_f}) + EW'($signed(power));

    // Negate is folded into the sign here, so S2 never needs it again.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cls_sign = in_float[FLOATSIZE-1] ^ negate;
        cls_exp  = e_sum[E-1:0];
        cls_sig  = in_float[S-1:0];
        cls_kind = FP_NORMAL;
        if (exp_f == '0)
            cls_kind = FP_ZERO;              // zero and denormals flush to zero
        else if (&exp_f)
            cls_kind = FP_SPECIAL;
        else if (e_sum >= OVF_LIMIT)
            cls_kind = FP_OVF;
        else if (e_sum[EW-1] || (e_sum == '0))
            cls_kind = FP_UNF;
    end

    always_comb begin
        res_float = {res_sign, {(FLOATSIZE-1){1'b0}}};
        res_ovf   = 1'b0;
        res_unf   = 1'b0;
        case (res_kind)
            FP_SPECIAL: res_float = {res_sign, INF_EXP, res_sig};  // payload kept
            FP_NORMAL:  res_float = {res_sign, res_exp, res_sig};
            FP_OVF: begin
                res_ovf = 1'b1;
                if (SATURATE != 0)
                    res_float = {res_sign, MAX_EXP, {S{1'b1}}};
                else
                    res_float = {res_sign, INF_EXP, {S{1'b0}}};
            end
            FP_UNF:     res_unf = 1'b1;
            default:    ;                    // FP_ZERO: signed zero
        endcase
    end

endmodule

// File: rtl/fp_scale_pow2_pipe.sv
// Pipelined multi-lane float multiply-by-2^k with per-lane negate.
// Two registered stages (S1 classify, S2 pack) on a valid/ready stream;
// latency 2, one beat per cycle when out_ready stays high.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake
//   in_data, in_power          lane floats and shared signed power k
//   in_negate                  per-lane sign flip
//   out_valid/out_ready        output handshake
//   out_data, out_ovf, out_unf results and per-lane flags
//   clear_sticky               clears sticky flags (wins over a set)
//   sticky_ovf, sticky_unf     any flagged beat delivered since last clear
module fp_scale_pow2_pipe
    import fp_pkg::*;
#(
    parameter int FLOATSIZE    = 16,
    parameter int EXPONENTSIZE = 5,
    parameter int LANES        = 4,
    parameter int POWER_WIDTH  = 6,
    parameter int SATURATE     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*FLOATSIZE-1:0]   in_data,
    input  logic [POWER_WIDTH-1:0]       in_power,
    input  logic [LANES-1:0]             in_negate,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*FLOATSIZE-1:0]   out_data,
    output logic [LANES-1:0]             out_ovf,
    output logic [LANES-1:0]             out_unf,
    input  logic                         clear_sticky,
    output logic                         sticky_ovf,
    output logic                         sticky_unf
);

    localparam int E = EXPONENTSIZE;
    localparam int S = sig_width(FLOATSIZE, EXPONENTSIZE);

    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv, in_hs;

    logic [LANES-1:0] c_sign, s1_sign;
    fp_class_e        c_kind [LANES];
    fp_class_e        s1_kind[LANES];
    logic [E-1:0]     c_exp  [LANES];
    logic [E-1:0]     s1_exp [LANES];
    logic [S-1:0]     c_sig  [LANES];
    logic [S-1:0]     s1_sig [LANES];

    logic [LANES*FLOATSIZE-1:0] res_data;
    logic [LANES-1:0]           res_ovf, res_unf;

    // A stage moves when it is empty or its successor moves.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign in_hs     = in_valid && in_ready;
    assign out_valid = s2_valid;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_scale_pow2_lane #(
            .FLOATSIZE   (FLOATSIZE),
            .EXPONENTSIZE(EXPONENTSIZE),
            .POWER_WIDTH (POWER_WIDTH),
            .SATURATE    (SATURATE)
        ) u_lane (
            .in_float (in_data[i*FLOATSIZE +: FLOATSIZE]),
            .power    (in_power),
            .negate   (in_negate[i]),
            .cls_sign (c_sign[i]),
            .cls_kind (c_kind[i]),
            .cls_exp  (c_exp[i]),
            .cls_sig  (c_sig[i]),
            .res_sign (s1_sign[i]),
            .res_kind (s1_kind[i]),
            .res_exp  (s1_exp[i]),
            .res_sig  (s1_sig[i]),
            .res_float(res_data[i*FLOATSIZE +: FLOATSIZE]),
            .res_ovf  (res_ovf[i]),
            .res_unf  (res_unf[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            s1_valid <= 1'b0;
        else if (s1_adv)
            s1_valid <= in_valid;
    end

    // NOTE: the S1 payload has no reset; s1_valid alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            s1_sign <= c_sign;
            for (int i = 0; i < LANES; i++) begin
                s1_kind[i] <= c_kind[i];
                s1_exp[i]  <= c_exp[i];
                s1_sig[i]  <= c_sig[i];
            end
        end
    end

    // S2 payload is the visible output, so it resets to zero and only
    // changes when a new beat moves in; it holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_ovf  <= '0;
            out_unf  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_data;
                out_ovf  <= res_ovf;
                out_unf  <= res_unf;
            end
        end
    end

    // Clear wins over a same-cycle set; that event is deliberately dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else if (clear_sticky) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (|out_ovf) sticky_ovf <= 1'b1;
            if (|out_unf) sticky_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_scale_pow2_pipe.sv
// Self-checking bench for fp_scale_pow2_pipe (fp16, 4 lanes).
// Two DUT copies share every input: SATURATE=1 and SATURATE=0.
module tb_fp_scale_pow2_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_power;
    logic [3:0]  in_negate;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_ovf, out_unf;
    logic        clear_sticky;
    logic        sticky_ovf, sticky_unf;

    logic        s0_in_ready, s0_out_valid;
    logic [63:0] s0_out_data;
    logic [3:0]  s0_out_ovf, s0_out_unf;
    logic        s0_sticky_ovf, s0_sticky_unf;

    fp_scale_pow2_pipe #(.SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_power(in_power), .in_negate(in_negate),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_unf(out_unf),
        .clear_sticky(clear_sticky),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
    );

    fp_scale_pow2_pipe #(.SATURATE(0)) dut_sat0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_data(in_data), .in_power(in_power), .in_negate(in_negate),
        .out_valid(s0_out_valid), .out_ready(out_ready),
        .out_data(s0_out_data), .out_ovf(s0_out_ovf), .out_unf(s0_out_unf),
        .clear_sticky(clear_sticky),
        .sticky_ovf(s0_sticky_ovf), .sticky_unf(s0_sticky_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [63:0] d1;   // SATURATE=1 result
        logic [63:0] d0;   // SATURATE=0 result
        logic [3:0]  ovf;
        logic [3:0]  unf;
    } exp_t;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  k;
        logic [3:0]  neg;
        logic [63:0] e1;
        logic [63:0] e0;
        logic [3:0]  ovf;
        logic [3:0]  unf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: value * 2^k on fp16 fields using plain integer exponent math.
    function automatic exp_t model(input logic [63:0] d, input logic [5:0] k, input logic [3:0] neg);
        exp_t r;
        int kk;
        kk = int'($signed(k));
        r.d1 = '0; r.d0 = '0; r.ovf = '0; r.unf = '0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] x, y1, y0;
            logic        s;
            int          e, sum;
            x   = d[i*16 +: 16];
            s   = x[15] ^ neg[i];
            e   = int'(x[14:10]);
            sum = e + kk;
            if (e == 0) begin
                y1 = {s, 15'h0000};
                y0 = y1;
            end else if (e == 31) begin
                y1 = {s, x[14:0]};
                y0 = y1;
            end else if (sum >= 31) begin
                y1 = {s, 15'h7BFF};
                y0 = {s, 15'h7C00};
                r.ovf[i] = 1'b1;
            end else if (sum <= 0) begin
                y1 = {s, 15'h0000};
                y0 = y1;
                r.unf[i] = 1'b1;
            end else begin
                y1 = {s, sum[4:0], x[9:0]};
                y0 = y1;
            end
            r.d1[i*16 +: 16] = y1;
            r.d0[i*16 +: 16] = y0;
        end
        return r;
    endfunction

    // Scoreboard: expectations queued on input handshake, compared on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready)
                sb.push_back(model(in_data, in_power, in_negate));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %h, expected no beat at %0t", out_data, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_data_sat1", out_data, e.d1);
                    check("sb_data_sat0", s0_out_data, e.d0);
                    check("sb_ovf", 64'(out_ovf), 64'(e.ovf));
                    check("sb_unf", 64'(out_unf), 64'(e.unf));
                end
            end
        end
    end

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [63:0] d, input logic [5:0] k, input logic [3:0] n);
        bit got;
        got       = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_power  = k;
        in_negate = n;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("in_ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check(name, 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid at a negedge; returns number of negedges skipped.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  stale;
        bit  done;

        vecs[0] = '{64'h0000_4000_BC00_3C00, 6'd4,  4'b0000,
                    64'h0000_5000_CC00_4C00, 64'h0000_5000_CC00_4C00, 4'b0000, 4'b0000};
        vecs[1] = '{64'h0000_7400_3C00_7800, 6'd2,  4'b0000,
                    64'h0000_7BFF_4400_7BFF, 64'h0000_7C00_4400_7C00, 4'b0101, 4'b0000};
        vecs[2] = '{64'h0000_3C00_8400_0400, 6'h3F, 4'b0000,
                    64'h0000_3800_8000_0000, 64'h0000_3800_8000_0000, 4'b0000, 4'b0011};
        vecs[3] = '{64'h0001_3C00_FC00_7E00, 6'd5,  4'b0011,
                    64'h0000_5000_7C00_FE00, 64'h0000_5000_7C00_FE00, 4'b0000, 4'b0000};
        vecs[4] = '{64'h0400_7BFF_8001_3555, 6'd0,  4'b0101,
                    64'h0400_FBFF_8000_B555, 64'h0400_FBFF_8000_B555, 4'b0000, 4'b0000};
        vecs[5] = '{64'h0000_7C00_C000_7BFF, 6'h20, 4'b0000,
                    64'h0000_7C00_8000_0000, 64'h0000_7C00_8000_0000, 4'b0000, 4'b0011};
        vecs[6] = '{64'h7C01_0001_FBFF_0400, 6'h1F, 4'b0100,
                    64'h7C01_8000_FBFF_7BFF, 64'h7C01_8000_FC00_7C00, 4'b0011, 4'b0000};
        vecs[7] = '{64'hBBFF_3800_3C00_7800, 6'h32, 4'b0000,
                    64'h8000_0000_0400_4000, 64'h8000_0000_0400_4000, 4'b0000, 4'b1100};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_power = '0;
        in_negate = '0; out_ready = 1'b1; clear_sticky = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        check("rst_out_flags", 64'({out_ovf, out_unf}), 64'(0));
        check("rst_sticky", 64'({sticky_ovf, sticky_unf}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Directed table, one beat at a time.
        foreach (vecs[v]) begin
            clear_sticky = 1'b1;
            @(posedge clk);
            #1 clear_sticky = 1'b0;
            send(vecs[v].data, vecs[v].k, vecs[v].neg);
            wait_out(lat);
            check("vec_latency", 64'(lat), 64'(1));
            check("vec_data_sat1", out_data, vecs[v].e1);
            check("vec_data_sat0", s0_out_data, vecs[v].e0);
            check("vec_ovf", 64'(out_ovf), 64'(vecs[v].ovf));
            check("vec_unf", 64'(out_unf), 64'(vecs[v].unf));
            @(negedge clk);
            check("vec_sticky_ovf", 64'(sticky_ovf), 64'(|vecs[v].ovf));
            check("vec_sticky_unf", 64'(sticky_unf), 64'(|vecs[v].unf));
            @(posedge clk);
            #1;
        end

        // Clear held through an overflowing output handshake: set is lost.
        clear_sticky = 1'b1;
        send(vecs[1].data, vecs[1].k, vecs[1].neg);
        wait_out(lat);
        @(negedge clk);
        check("clear_priority", 64'(sticky_ovf), 64'(0));
        @(posedge clk);
        #1 clear_sticky = 1'b0;
        send(vecs[2].data, vecs[2].k, vecs[2].neg);
        wait_out(lat);
        @(negedge clk);
        check("sticky_unf_set", 64'(sticky_unf), 64'(1));
        @(posedge clk);
        #1 clear_sticky = 1'b1;
        @(posedge clk);
        #1 clear_sticky = 1'b0;
        @(negedge clk);
        check("sticky_unf_clear", 64'(sticky_unf), 64'(0));
        @(posedge clk);
        #1;

        // Backpressure: 6 beats with out_ready low early on.
        out_ready = 1'b0;
        fork
            begin
                for (int b = 0; b < 6; b++)
                    send({$urandom, $urandom}, 6'($urandom), 4'($urandom));
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_full", 64'(in_ready), 64'(0));
                check("bp_out_valid", 64'(out_valid), 64'(1));
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Random traffic with random stalls.
        done = 1'b0;
        fork
            begin
                for (int b = 0; b < 300; b++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send({$urandom, $urandom}, 6'($urandom), 4'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("rand_drain");

        // Reset with two beats in flight.
        send(vecs[1].data, vecs[1].k, vecs[1].neg);
        drain("pre_rst_drain");
        @(negedge clk);
        check("pre_rst_sticky_ovf", 64'(sticky_ovf), 64'(1));
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(vecs[0].data, vecs[0].k, vecs[0].neg);
        send(vecs[2].data, vecs[2].k, vecs[2].neg);
        @(negedge clk);
        check("inflight_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_sticky", 64'({sticky_ovf, sticky_unf}), 64'(0));
        check("midrst_out_data", out_data, 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("no_stale_beat", 64'(stale), 64'(0));
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
